// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and register-file write-back decode.
//
// Captures the MEM-stage instruction on each unstalled clock edge and decodes
// the register-file write from the registered fields: ALU result, load data
// (byte/half/word extraction with sign or zero extension), PC+4, or zero.
// Misaligned loads are flagged and suppress the register write.
//
// Optional feature: define WB_INSTRET_EN to build the 64-bit retired-
// instruction counter on o_instret; otherwise o_instret is tied to zero.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-low reset
//   i_stall, i_flush    hold the register / load a bubble (flush wins)
//   i_valid, i_rd_addr, i_rd_wren, i_wb_sel, i_alu_data, i_ld_data,
//   i_ld_size, i_addr_lo, i_pc4   MEM-stage instruction fields
//   o_rd_addr, o_rd_data, o_rd_wren   register-file write port
//   o_valid, o_misalign               WB-stage status
//   o_instret                         retired-instruction count
module wb_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_ld_data,
  input  logic [2:0]  i_ld_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_pc4,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic        o_valid,
  output logic        o_misalign,
  output logic [63:0] o_instret
);

  // Load size classes from funct3 low bits: x00 byte, x01 half, x1x word
  // (undefined codes 011/110/111 fall into the word class).
  function automatic logic calc_misalign(input logic       valid,
                                         input logic [1:0] sel,
                                         input logic [2:0] size,
                                         input logic [1:0] off);
    logic is_half;
    logic is_word;
    is_half = (size[1:0] == 2'b01);
    is_word = size[1];
    return valid && (sel == 2'b01) &&
           ((is_half && off[0]) || (is_word && (off != 2'b00)));
  endfunction

  logic        valid_q;
  logic        wren_q;
  logic [4:0]  rd_q;
  logic [1:0]  sel_q;
  logic [31:0] alu_q;
  logic [31:0] ld_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] pc4_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      wren_q  <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      pc4_q   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      wren_q  <= 1'b0;
    end else if (!i_stall) begin
      valid_q <= i_valid;
      wren_q  <= i_valid & i_rd_wren;
      rd_q    <= i_rd_addr;
      sel_q   <= i_wb_sel;
      alu_q   <= i_alu_data;
      ld_q    <= i_ld_data;
      size_q  <= i_ld_size;
      off_q   <= i_addr_lo;
      pc4_q   <= i_pc4;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    ld_val  = '0;
    case (off_q)
      2'd0:    ld_byte = ld_q[7:0];
      2'd1:    ld_byte = ld_q[15:8];
      2'd2:    ld_byte = ld_q[23:16];
      default: ld_byte = ld_q[31:24];
    endcase
    ld_half = off_q[1] ? ld_q[31:16] : ld_q[15:0];
    case (size_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = ld_q;
    endcase
  end

  always_comb begin
    o_rd_data = '0;
    case (sel_q)
      2'b00:   o_rd_data = alu_q;
      2'b01:   o_rd_data = ld_val;
      2'b10:   o_rd_data = pc4_q;
      default: o_rd_data = '0;
    endcase
  end

  assign o_valid    = valid_q;
  assign o_misalign = calc_misalign(valid_q, sel_q, size_q, off_q);
  assign o_rd_wren  = valid_q & wren_q & (rd_q != 5'd0) & ~o_misalign;
  assign o_rd_addr  = o_rd_wren ? rd_q : 5'd0;

`ifdef WB_INSTRET_EN
  logic [63:0] instret;

  // Counts at capture time from the incoming fields, so the count moves on
  // the same edge the retiring instruction enters WB.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      instret <= '0;
    end else if (!i_flush && !i_stall && i_valid &&
                 !calc_misalign(1'b1, i_wb_sel, i_ld_size, i_addr_lo)) begin
      instret <= instret + 64'd1;
    end
  end

  assign o_instret = instret;
`else
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_data;
  logic [31:0] i_ld_data;
  logic [2:0]  i_ld_size;
  logic [1:0]  i_addr_lo;
  logic [31:0] i_pc4;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic        o_valid;
  logic        o_misalign;
  logic [63:0] o_instret;

  wb_stage dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_rd_addr  (i_rd_addr),
    .i_rd_wren  (i_rd_wren),
    .i_wb_sel   (i_wb_sel),
    .i_alu_data (i_alu_data),
    .i_ld_data  (i_ld_data),
    .i_ld_size  (i_ld_size),
    .i_addr_lo  (i_addr_lo),
    .i_pc4      (i_pc4),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wren  (o_rd_wren),
    .o_valid    (o_valid),
    .o_misalign (o_misalign),
    .o_instret  (o_instret)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] LD_WORD = 32'h8899AABB;
  localparam logic [31:0] PC4     = 32'h00001004;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        wren;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [2:0]  size;
    logic [1:0]  off;
    logic        e_valid;
    logic        e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic [63:0] instret;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[21];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [63:0] exp_instret = '0;

  function automatic vec_t mk(logic valid, logic flush, logic wren,
                              logic [4:0] rd, logic [1:0] sel,
                              logic [31:0] alu, logic [2:0] size,
                              logic [1:0] off, logic e_valid, logic e_wren,
                              logic [4:0] e_addr, logic [31:0] e_data,
                              logic e_mis);
    vec_t v;
    v.valid = valid; v.flush = flush; v.wren = wren; v.rd = rd;
    v.sel = sel; v.alu = alu; v.size = size; v.off = off;
    v.e_valid = e_valid; v.e_wren = e_wren; v.e_addr = e_addr;
    v.e_data = e_data; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".valid"}, 64'(o_valid), 64'(e.valid));
    check({e.name, ".wren"}, 64'(o_rd_wren), 64'(e.wren));
    check({e.name, ".addr"}, 64'(o_rd_addr), 64'(e.addr));
    check({e.name, ".mis"}, 64'(o_misalign), 64'(e.mis));
    check({e.name, ".instret"}, o_instret, e.instret);
    if (e.chk_data) check({e.name, ".data"}, 64'(o_rd_data), 64'(e.data));
  endtask

  task automatic set_in(logic rst, logic stall, logic flush, logic valid,
                        logic wren, logic [4:0] rd, logic [1:0] sel,
                        logic [31:0] alu, logic [2:0] size, logic [1:0] off);
    i_reset = rst; i_stall = stall; i_flush = flush; i_valid = valid;
    i_rd_wren = wren; i_rd_addr = rd; i_wb_sel = sel; i_alu_data = alu;
    i_ld_data = LD_WORD; i_ld_size = size; i_addr_lo = off; i_pc4 = PC4;
  endtask

  task automatic push(string name, logic valid, logic wren, logic [4:0] addr,
                      logic [31:0] data, logic chk_data, logic mis);
    exp_t e;
    e.name = name; e.valid = valid; e.wren = wren; e.addr = addr;
    e.data = data; e.chk_data = chk_data; e.mis = mis;
`ifdef WB_INSTRET_EN
    e.instret = exp_instret;
`else
    e.instret = '0;
`endif
    sb.push_back(e);
  endtask

  // One unstalled instruction: drive, predict, clock, compare.
  task automatic run_vec(string name, vec_t v);
    @(negedge i_clk);
    set_in(1'b1, 1'b0, v.flush, v.valid, v.wren, v.rd, v.sel, v.alu,
           v.size, v.off);
    if (v.e_valid && !v.e_mis) exp_instret = exp_instret + 64'd1;
    push(name, v.e_valid, v.e_wren, v.e_addr, v.e_data, v.e_valid, v.e_mis);
    @(posedge i_clk);
    #1 pop_compare();
  endtask

  task automatic do_reset(string name);
    @(negedge i_clk);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'b00, 32'hFFFF_FFFF,
           3'b010, 2'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    exp_instret = '0;
    push(name, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    #1 pop_compare();
    @(negedge i_clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 3'b010, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1,0,1,5'd5,2'b00,32'hDEADBEEF,3'b010,2'd0, 1,1,5'd5,32'hDEADBEEF,0);
    vecs[1]  = mk(1,0,1,5'd0,2'b00,32'hDEADBEEF,3'b010,2'd0, 1,0,5'd0,32'hDEADBEEF,0);
    vecs[2]  = mk(1,0,1,5'd7,2'b01,32'd0,3'b000,2'd2, 1,1,5'd7,32'hFFFFFF99,0);
    vecs[3]  = mk(1,0,1,5'd7,2'b01,32'd0,3'b100,2'd2, 1,1,5'd7,32'h00000099,0);
    vecs[4]  = mk(1,0,1,5'd7,2'b01,32'd0,3'b001,2'd2, 1,1,5'd7,32'hFFFF8899,0);
    vecs[5]  = mk(1,0,1,5'd7,2'b01,32'd0,3'b101,2'd0, 1,1,5'd7,32'h0000AABB,0);
    vecs[6]  = mk(1,0,1,5'd7,2'b01,32'd0,3'b010,2'd0, 1,1,5'd7,32'h8899AABB,0);
    vecs[7]  = mk(1,0,1,5'd8,2'b01,32'd0,3'b000,2'd3, 1,1,5'd8,32'hFFFFFF88,0);
    vecs[8]  = mk(1,0,1,5'd8,2'b01,32'd0,3'b100,2'd1, 1,1,5'd8,32'h000000AA,0);
    vecs[9]  = mk(1,0,1,5'd8,2'b01,32'd0,3'b000,2'd0, 1,1,5'd8,32'hFFFFFFBB,0);
    vecs[10] = mk(1,0,1,5'd7,2'b01,32'd0,3'b001,2'd1, 1,0,5'd0,32'hFFFFAABB,1);
    vecs[11] = mk(1,0,1,5'd7,2'b01,32'd0,3'b010,2'd2, 1,0,5'd0,32'h8899AABB,1);
    vecs[12] = mk(1,0,1,5'd7,2'b01,32'd0,3'b011,2'd0, 1,1,5'd7,32'h8899AABB,0);
    vecs[13] = mk(1,0,1,5'd7,2'b01,32'd0,3'b111,2'd1, 1,0,5'd0,32'h8899AABB,1);
    vecs[14] = mk(1,0,1,5'd1,2'b10,32'h11111111,3'b010,2'd0, 1,1,5'd1,32'h00001004,0);
    vecs[15] = mk(1,0,1,5'd2,2'b11,32'h11111111,3'b010,2'd0, 1,1,5'd2,32'h00000000,0);
    vecs[16] = mk(0,0,1,5'd6,2'b00,32'h22222222,3'b010,2'd0, 0,0,5'd0,32'h0,0);
    vecs[17] = mk(1,1,1,5'd6,2'b00,32'h33333333,3'b010,2'd0, 0,0,5'd0,32'h0,0);
    vecs[18] = mk(1,0,0,5'd3,2'b00,32'h00000055,3'b010,2'd0, 1,0,5'd0,32'h00000055,0);
    vecs[19] = mk(1,0,1,5'd7,2'b01,32'd0,3'b101,2'd1, 1,0,5'd0,32'h0000AABB,1);
    vecs[20] = mk(1,0,1,5'd4,2'b10,32'd0,3'b001,2'd1, 1,1,5'd4,32'h00001004,0);

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 3'b010, 2'd0);
    do_reset("reset");

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stall: new inputs ignored for 3 cycles, then flush overrides stall.
    run_vec("stall_pre", vecs[0]);
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge i_clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 2'b00, 32'h12345678,
             3'b010, 2'd0);
      push($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd5, 32'hDEADBEEF,
           1'b1, 1'b0);
      @(posedge i_clk);
      #1 pop_compare();
    end
    @(negedge i_clk);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'b00, 32'h12345678,
           3'b010, 2'd0);
    push("stall_flush", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 pop_compare();

    // Reset with a valid write in WB discards it.
    run_vec("pre_rst", vecs[14]);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    exp_instret = '0;
    push("rst_discard", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    @(posedge i_clk);
    #1 pop_compare();
    @(negedge i_clk);
    i_reset = 1'b1;

`ifdef WB_INSTRET_EN
    do_reset("reset2");
    for (int unsigned k = 0; k < 10; k++) begin
      vec_t v;
      v = vecs[0];
      if (k == 3 || k == 7) begin
        v.flush = 1'b1; v.e_valid = 1'b0; v.e_wren = 1'b0; v.e_addr = 5'd0;
      end
      run_vec($sformatf("ret%0d", k), v);
    end
    check("instret_eight", o_instret, 64'd8);
    @(negedge i_clk);
    i_stall = 1'b1;
    force dut.instret = '1;
    #1 release dut.instret;
    check("instret_forced", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_instret = '1;
    run_vec("instret_wrap", vecs[0]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
